// File: rtl/fact_pkg.sv
// Shared definitions for the memory-mapped factorial accelerator:
// register offsets, FSM state encoding and the largest legal operand.
package fact_pkg;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] FACT_N    = 2'b00;
    localparam logic [1:0] FACT_GO   = 2'b01;
    localparam logic [1:0] FACT_STAT = 2'b10;
    localparam logic [1:0] FACT_RES  = 2'b11;

    // Largest N whose factorial still fits in 32 bits (12! = 479001600)
    localparam int N_MAX = 12;

    // Bus data width
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fact_state_t;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: one multiply per clock, counting cnt down
// from N to 1. Holds the sticky DONE/ERR flags and the published RESULT,
// which only changes when a computation finishes or an over-range GO
// is rejected.
module fact_core
    import fact_pkg::*;
#(
    parameter int N_W   = 4,
    parameter int N_MAX = fact_pkg::N_MAX
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_W-1:0]    n,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    fact_state_t       state_q, state_d;
    logic [N_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] n_ext;
    logic [DATA_W-1:0] cnt_ext;

    // Product truncated to the bus width; cannot overflow for N <= N_MAX
    function automatic logic [DATA_W-1:0] mul_trunc(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        return a * b;
    endfunction

    assign n_ext   = {{(DATA_W-N_W){1'b0}}, n};
    assign cnt_ext = {{(DATA_W-N_W){1'b0}}, cnt_q};

    // Next-state and datapath decisions for IDLE/BUSY
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        result_d = result_q;
        done_d   = done_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_ext > DATA_W'(N_MAX)) begin
                        err_d    = 1'b1;
                        done_d   = 1'b0;
                        result_d = '0;
                    end else begin
                        cnt_d   = n;
                        prod_d  = DATA_W'(1);
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q <= N_W'(1)) begin
                    result_d = prod_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    prod_d = mul_trunc(prod_q, cnt_ext);
                    cnt_d  = cnt_q - N_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any computation at once
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign busy   = (state_q == BUSY);

endmodule

// File: rtl/fact_mmio_slave.sv
// Data-bus slave wrapping fact_core: holds the N register, decodes writes
// into N updates and one-cycle GO pulses, and drives the combinational
// read mux for the 16-byte window.
module fact_mmio_slave
    import fact_pkg::*;
#(
    parameter int N_W   = 4,
    parameter int N_MAX = fact_pkg::N_MAX
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        busy
);

    logic [N_W-1:0]    n_q;
    logic              wr_en;
    logic [1:0]        offset;
    logic              start;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;

    // Byte-lane bits and the upper write-data bits are not decoded
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wd[31:N_W]};

    assign wr_en  = sel & we;
    assign offset = addr[3:2];
    assign start  = wr_en && (offset == FACT_GO) && wd[0];

    // N operand register; may be rewritten while the core is busy
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            n_q <= '0;
        end else if (wr_en && (offset == FACT_N)) begin
            n_q <= wd[N_W-1:0];
        end
    end

    fact_core #(
        .N_W   (N_W),
        .N_MAX (N_MAX)
    ) u_core (
        .Clk    (Clk),
        .reset  (reset),
        .start  (start),
        .n      (n_q),
        .done   (done),
        .err    (err),
        .result (result),
        .busy   (busy)
    );

    // Combinational read mux; deselected slave drives zero onto the bus
    always_comb begin
        rd = '0;
        if (sel) begin
            case (offset)
                FACT_N:    rd = {{(DATA_W-N_W){1'b0}}, n_q};
                FACT_GO:   rd = '0;
                FACT_STAT: rd = {30'b0, err, done};
                FACT_RES:  rd = result;
                default:   rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_mmio_slave.sv
// Directed bench for fact_mmio_slave: bus writes/reads with
// hand-computed factorial results and cycle-exact STATUS checks.
`timescale 1ns/1ps
module tb_fact_mmio_slave;

    logic        Clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        busy;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] A_N    = 4'h0;
    localparam logic [3:0] A_GO   = 4'h4;
    localparam logic [3:0] A_STAT = 4'h8;
    localparam logic [3:0] A_RES  = 4'hC;

    fact_mmio_slave dut (
        .Clk   (Clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wd    (wd),
        .rd    (rd),
        .busy  (busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Drive one bus write, let it land on the next rising edge, return 1ns later
    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        sel  = 1'b1;
        we   = 1'b1;
        addr = a;
        wd   = d;
        @(posedge Clk);
        #1;
        sel = 1'b0;
        we  = 1'b0;
        wd  = '0;
    endtask

    // Combinational bus read
    task automatic rd_reg(input logic [3:0] a, output logic [31:0] v);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        v   = rd;
        sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        for (int i = 0; i < 4; i++) begin
            rd_reg(4'(i * 4), v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_rd off=%0d got=%h exp=00000000", i * 4, v); end
        end
        @(negedge Clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_fact5();
        logic [31:0] v;
        do_write(A_N, 32'd5);
        rd_reg(A_N, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL f5_nreg got=%h exp=00000005", v); end
        do_write(A_GO, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge Clk); #1;
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL f5_busy cyc=%0d got=%b exp=1", k, busy); end
            rd_reg(A_STAT, v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL f5_stat cyc=%0d got=%h exp=00000000", k, v); end
        end
        @(posedge Clk); #1;
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL f5_done got=%h exp=00000001", v); end
        rd_reg(A_RES, v);
        total++; if (v !== 32'h78) begin bad++; $display("FAIL f5_result got=%h exp=00000078", v); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL f5_idle got=%b exp=0", busy); end
    endtask

    task automatic test_small();
        logic [31:0] v;
        for (int n = 0; n < 2; n++) begin
            do_write(A_N, 32'(n));
            do_write(A_GO, 32'd1);
            rd_reg(A_STAT, v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL small_clr n=%0d got=%h exp=00000000", n, v); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL small_busy n=%0d got=%b exp=1", n, busy); end
            @(posedge Clk); #1;
            rd_reg(A_STAT, v);
            total++; if (v !== 32'h1) begin bad++; $display("FAIL small_stat n=%0d got=%h exp=00000001", n, v); end
            rd_reg(A_RES, v);
            total++; if (v !== 32'h1) begin bad++; $display("FAIL small_res n=%0d got=%h exp=00000001", n, v); end
        end
    endtask

    task automatic test_range();
        logic [31:0] v;
        do_write(A_N, 32'd12);
        do_write(A_GO, 32'd1);
        repeat (11) @(posedge Clk);
        #1;
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL n12_early got=%h exp=00000000", v); end
        @(posedge Clk); #1;
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL n12_stat got=%h exp=00000001", v); end
        rd_reg(A_RES, v);
        total++; if (v !== 32'h1C8CFC00) begin bad++; $display("FAIL n12_res got=%h exp=1c8cfc00", v); end
        do_write(A_N, 32'd13);
        do_write(A_GO, 32'd1);
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL n13_stat got=%h exp=00000002", v); end
        rd_reg(A_RES, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL n13_res got=%h exp=00000000", v); end
        for (int k = 0; k < 3; k++) begin
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL n13_busy cyc=%0d got=%b exp=0", k, busy); end
            @(posedge Clk); #1;
        end
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL n13_sticky got=%h exp=00000002", v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        do_write(A_N, 32'd6);
        do_write(A_GO, 32'd1);
        do_write(A_N, 32'd3);
        do_write(A_GO, 32'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        repeat (3) @(posedge Clk);
        #1;
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL b2b_early got=%h exp=00000000", v); end
        @(posedge Clk); #1;
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL b2b_stat got=%h exp=00000001", v); end
        rd_reg(A_RES, v);
        total++; if (v !== 32'h2D0) begin bad++; $display("FAIL b2b_res got=%h exp=000002d0", v); end
        rd_reg(A_N, v);
        total++; if (v !== 32'd3) begin bad++; $display("FAIL b2b_nreg got=%h exp=00000003", v); end
        do_write(A_GO, 32'd1);
        repeat (2) @(posedge Clk);
        #1;
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL b2b3_early got=%h exp=00000000", v); end
        rd_reg(A_RES, v);
        total++; if (v !== 32'h2D0) begin bad++; $display("FAIL b2b3_hold got=%h exp=000002d0", v); end
        @(posedge Clk); #1;
        rd_reg(A_RES, v);
        total++; if (v !== 32'h6) begin bad++; $display("FAIL b2b3_res got=%h exp=00000006", v); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] v;
        do_write(A_N, 32'd7);
        do_write(A_GO, 32'd1);
        repeat (3) @(posedge Clk);
        #3;
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL abort_stat got=%h exp=00000000", v); end
        rd_reg(A_RES, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL abort_res got=%h exp=00000000", v); end
        rd_reg(A_N, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL abort_nreg got=%h exp=00000000", v); end
        @(negedge Clk);
        reset = 1'b0;
        #1;
        do_write(A_N, 32'd4);
        do_write(A_GO, 32'd1);
        repeat (3) @(posedge Clk);
        #1;
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL n4_early got=%h exp=00000000", v); end
        @(posedge Clk); #1;
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL n4_stat got=%h exp=00000001", v); end
        rd_reg(A_RES, v);
        total++; if (v !== 32'h18) begin bad++; $display("FAIL n4_res got=%h exp=00000018", v); end
    endtask

    task automatic test_bus_rules();
        logic [31:0] v;
        sel  = 1'b0;
        we   = 1'b1;
        addr = A_GO;
        wd   = 32'd1;
        @(posedge Clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nosel_go busy got=%b exp=0", busy); end
        for (int i = 0; i < 4; i++) begin
            addr = 4'(i * 4);
            #1;
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL nosel_rd off=%0d got=%h exp=00000000", i * 4, rd); end
        end
        we = 1'b0;
        wd = '0;
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL nosel_stat got=%h exp=00000001", v); end
        rd_reg(A_GO, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL go_read got=%h exp=00000000", v); end
        do_write(A_RES, 32'hDEADBEEF);
        rd_reg(A_RES, v);
        total++; if (v !== 32'h18) begin bad++; $display("FAIL res_ro got=%h exp=00000018", v); end
        do_write(A_STAT, 32'h3);
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL stat_ro got=%h exp=00000001", v); end
        do_write(A_GO, 32'h2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL go0_busy got=%b exp=0", busy); end
        rd_reg(A_STAT, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL go0_stat got=%h exp=00000001", v); end
    endtask

    initial begin
        reset = 1'b1;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wd    = '0;
        #12;
        test_reset();
        test_fact5();
        test_small();
        test_range();
        test_back_to_back();
        test_reset_abort();
        test_bus_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
